// File: rtl/trng_pkg.sv
// trng_pkg: FSM state encoding and default parameters shared by the TRNG sampler.
package trng_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_COLLECT, S_HOLD, S_FAIL} state_t;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_SAMPLE_DIV = 4;
  localparam int DEF_WARMUP_SAMPLES = 64;
  localparam int DEF_REP_CUTOFF = 32;
endpackage

// File: rtl/trng_sync2.sv
// trng_sync2: two-flop synchronizer bringing the ring-oscillator bit into the clk domain.
module trng_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_ff;
  always_ff @(posedge clk)
    if (!rst_n) r_ff <= '0;
    else r_ff <= {r_ff[0], i_d};
  assign o_q = r_ff[1];
endmodule

// File: rtl/trng_sampler.sv
// trng_sampler: samples a ring-oscillator bit, runs warmup and a repetition health test, packs words.
// Optional von Neumann debiasing of collected samples is enabled by defining TRNG_VN_DEBIAS_EN.
module trng_sampler
  import trng_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int WARMUP_SAMPLES = DEF_WARMUP_SAMPLES,
  parameter int REP_CUTOFF = DEF_REP_CUTOFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              raw_bit,
  input  logic              enable,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              health_fail,
  output logic              busy
);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int WW = $clog2(WARMUP_SAMPLES + 1);
  localparam int RW = $clog2(REP_CUTOFF + 1);
  localparam int BW = $clog2(WORD_W + 1);
  state_t r_state;
  logic [DW-1:0] r_div;
  logic [WW-1:0] r_warm;
  logic [RW-1:0] r_rep;
  logic [BW-1:0] r_cnt;
  logic [WORD_W-1:0] r_data;
  logic r_last, r_valid, r_fail, r_busy;
  logic w_s_bit, w_tick, w_live, w_fail, w_acc, w_acc_bit;
  logic [RW-1:0] w_rep_nxt;

  trng_sync2 u_sync (.clk(clk), .rst_n(rst_n), .i_d(raw_bit), .o_q(w_s_bit));

  assign w_tick = r_div == DW'(SAMPLE_DIV - 1);
  assign w_live = r_state == S_WARMUP || r_state == S_COLLECT || r_state == S_HOLD;
  // A zero run length means no previous sample has been seen yet
  assign w_rep_nxt = (r_rep != '0 && w_s_bit == r_last) ? r_rep + 1'b1 : RW'(1);
  assign w_fail = w_live && w_tick && w_rep_nxt >= RW'(REP_CUTOFF);

`ifdef TRNG_VN_DEBIAS_EN
  logic r_pair_have, r_pair_bit;
  always_ff @(posedge clk)
    if (!rst_n || r_state != S_COLLECT) begin
      r_pair_have <= 1'b0;
      r_pair_bit <= 1'b0;
    end else if (w_tick) begin
      r_pair_have <= !r_pair_have;
      r_pair_bit <= w_s_bit;
    end
  assign w_acc = w_tick && r_pair_have && w_s_bit != r_pair_bit;
  assign w_acc_bit = r_pair_bit;
`else
  assign w_acc = w_tick;
  assign w_acc_bit = w_s_bit;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      r_state <= S_IDLE;
      r_div <= '0;
      r_warm <= '0;
      r_rep <= '0;
      r_last <= 1'b0;
      r_cnt <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_fail <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_busy <= 1'b1;
      r_div <= (r_state == S_IDLE || w_tick) ? '0 : r_div + 1'b1;
      if (w_live && w_tick) begin
        r_rep <= w_rep_nxt;
        r_last <= w_s_bit;
      end
      // Health failure wins over any handshake on the same edge
      if (w_fail) begin
        r_state <= S_FAIL;
        r_valid <= 1'b0;
        r_fail <= 1'b1;
        r_data <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_WARMUP;
          S_WARMUP:
            if (w_tick) begin
              r_warm <= r_warm + 1'b1;
              if (r_warm == WW'(WARMUP_SAMPLES - 1)) r_state <= S_COLLECT;
            end
          S_COLLECT:
            if (w_acc) begin
              r_data <= {w_acc_bit, r_data[WORD_W-1:1]};
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt == BW'(WORD_W - 1)) begin
                r_state <= S_HOLD;
                r_valid <= 1'b1;
              end
            end
          S_HOLD:
            if (out_ready) begin
              r_state <= S_COLLECT;
              r_valid <= 1'b0;
              r_cnt <= '0;
            end
          default: ;
        endcase
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data = r_data;
  assign health_fail = r_fail;
  assign busy = r_busy;
endmodule

// File: tb/tb_trng_sampler.sv
// tb_trng_sampler: directed and random checks of trng_sampler against a sample-level reference model.
module tb_trng_sampler;
  localparam int W = 32, DIV = 4, WARM = 64, CUT = 32;
`ifdef TRNG_VN_DEBIAS_EN
  localparam int ALT_N = WARM + 2 * W;
  localparam logic [W-1:0] ALT_WORD = 32'hFFFF_FFFF;
  localparam int PAT_N = WARM + 4 * W;
  localparam logic [W-1:0] PAT_WORD = 32'h5555_5555;
`else
  localparam int ALT_N = WARM + W;
  localparam logic [W-1:0] ALT_WORD = 32'h5555_5555;
  localparam int PAT_N = WARM + W;
  localparam logic [W-1:0] PAT_WORD = 32'h3939_3939;
`endif

  logic clk = 1'b0, rst_n, raw_bit, enable, out_ready;
  logic out_valid, health_fail, busy;
  logic [W-1:0] out_data;
  int n_cmp = 0, n_bad = 0;

  trng_sampler #(.WORD_W(W), .SAMPLE_DIV(DIV), .WARMUP_SAMPLES(WARM), .REP_CUTOFF(CUT)) dut (
    .clk(clk), .rst_n(rst_n), .raw_bit(raw_bit), .enable(enable), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .health_fail(health_fail), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: tracks samples taken since enable, run length, and word assembly
  logic m_active, m_failed, m_hf, m_valid;
  logic [W-1:0] m_data, m_acc;
  int m_k, m_nsamp, m_rep, m_nbits, m_pair;
  logic m_last;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    m_active = 0; m_failed = 0; m_hf = 0; m_valid = 0; m_data = '0; m_acc = '0;
    m_k = 0; m_nsamp = 0; m_rep = 0; m_nbits = 0; m_pair = -1; m_last = 0;
  endtask

  task automatic m_push(input logic b);
    m_acc[m_nbits] = b;
    m_nbits++;
    if (m_nbits == W) begin
      m_valid = 1;
      m_data = m_acc;
    end
  endtask

  task automatic model(input logic r, input logic rdy, input logic en, input logic rs);
    logic smp;
    if (!rs || !en) begin
      m_clear();
      return;
    end
    if (!m_active) begin
      m_active = 1;
      m_k = 0;
      return;
    end
    m_k++;
    smp = (m_k % DIV) == 0;
    if (m_failed) return;
    if (smp) begin
      m_rep = (m_nsamp > 0 && r == m_last) ? m_rep + 1 : 1;
      m_last = r;
      m_nsamp++;
      if (m_rep >= CUT) begin
        m_failed = 1; m_hf = 1; m_valid = 0; m_data = '0;
        return;
      end
    end
    if (m_valid && rdy) begin
      m_valid = 0; m_nbits = 0; m_acc = '0; m_pair = -1;
      return;
    end
    if (smp && m_nsamp > WARM && !m_valid) begin
`ifdef TRNG_VN_DEBIAS_EN
      if (m_pair < 0) m_pair = int'(r);
      else begin
        if (m_pair != int'(r)) m_push(logic'(m_pair));
        m_pair = -1;
      end
`else
      m_push(r);
`endif
    end
  endtask

  task automatic cyc(input logic r, input logic rdy);
    raw_bit = r;
    out_ready = rdy;
    @(posedge clk);
    model(r, rdy, enable, rst_n);
    #1;
    cmp("ctl", 64'({busy, health_fail, out_valid}), 64'({m_active, m_hf, m_valid}));
    if (m_valid || m_failed || !m_active) cmp("data", 64'(out_data), 64'(m_data));
  endtask

  // One sample window: raw held for DIV clocks so the synchronized sample is unambiguous
  task automatic samp(input logic v, input logic rdy);
    cyc(v, rdy);
    for (int i = 1; i < DIV; i++) cyc(v, 1'b0);
  endtask

  task automatic start();
    enable = 1;
    cyc(1'b0, 1'b0);
  endtask

  task automatic stop();
    enable = 0;
    cyc(1'b0, 1'b0);
    cmp("stop_idle", 64'({busy, health_fail, out_valid}), 64'd0);
  endtask

  initial begin
    logic [7:0] pat;
    pat = 8'b0011_1001;
    m_clear();
    rst_n = 0; enable = 0; raw_bit = 0; out_ready = 0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cmp("reset_state", 64'({busy, health_fail, out_valid, out_data}), 64'd0);
    rst_n = 1;
    cyc(1'b0, 1'b0);
    // Alternating samples: word appears only after warmup plus a full word of samples
    start();
    cmp("busy_on", 64'(busy), 64'd1);
    for (int n = 1; n <= ALT_N; n++) begin
      samp(logic'(n % 2), 1'b0);
      if (n == ALT_N - 1) cmp("alt_not_yet", 64'(out_valid), 64'd0);
    end
    cmp("alt_valid", 64'(out_valid), 64'd1);
    cmp("alt_word", 64'(out_data), 64'(ALT_WORD));
    for (int n = ALT_N + 1; n <= ALT_N + 25; n++) samp(logic'(n % 2), 1'b0);
    cmp("hold_valid", 64'(out_valid), 64'd1);
    cmp("hold_word", 64'(out_data), 64'(ALT_WORD));
    cyc(logic'((ALT_N + 26) % 2), 1'b1);
    cmp("xfer_done", 64'(out_valid), 64'd0);
    for (int i = 1; i < DIV; i++) cyc(logic'((ALT_N + 26) % 2), 1'b0);
    for (int n = ALT_N + 27; n <= ALT_N + 27 + 2 * W + 8; n++) samp(logic'(n % 2), 1'b0);
    cmp("hold2_valid", 64'(out_valid), 64'd1);
    stop();
    cmp("drop_valid", 64'(out_valid), 64'd0);
    // Re-enable repeats the full warmup
    start();
    for (int n = 1; n < ALT_N; n++) samp(logic'(n % 2), 1'b0);
    cmp("rewarm_not_yet", 64'(out_valid), 64'd0);
    samp(logic'(ALT_N % 2), 1'b0);
    cmp("rewarm_valid", 64'(out_valid), 64'd1);
    cmp("rewarm_word", 64'(out_data), 64'(ALT_WORD));
    stop();
    // Pair pattern 10,01,11,00
    start();
    for (int n = 1; n <= PAT_N; n++) samp(pat[(n - 1) % 8], 1'b0);
    cmp("pat_valid", 64'(out_valid), 64'd1);
    cmp("pat_word", 64'(out_data), 64'(PAT_WORD));
    stop();
    // Stuck-at-one trips the repetition test on the cutoff sample
    start();
    for (int n = 1; n < CUT; n++) samp(1'b1, 1'b0);
    cmp("stuck_pre", 64'(health_fail), 64'd0);
    samp(1'b1, 1'b0);
    cmp("stuck_fail", 64'({health_fail, out_valid, out_data}), 64'({1'b1, 1'b0, 32'd0}));
    for (int n = 0; n < 4; n++) samp(1'b1, 1'b1);
    cmp("stuck_sticky", 64'(health_fail), 64'd1);
    stop();
    cmp("stuck_clear", 64'(health_fail), 64'd0);
    // Random bits with random acceptance
    start();
    for (int n = 0; n < 400; n++) samp(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0));
    stop();
    // Reset pulse in the middle of collecting
    start();
    for (int n = 1; n <= WARM + 6; n++) samp(logic'(n % 2), 1'b0);
    rst_n = 0;
    cyc(1'b0, 1'b0);
    cmp("rst_mid", 64'({busy, health_fail, out_valid, out_data}), 64'd0);
    rst_n = 1;
    start();
    for (int n = 1; n <= 8; n++) samp(logic'(n % 2), 1'b0);
    stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/trng_sampler.md
TRNG_SAMPLER -- requirements
Module: trng_sampler

Interface
REQ-001 SHALL have parameter WORD_W, default 32, output word width in bits.
REQ-002 SHALL have parameter SAMPLE_DIV, default 4, clocks between raw-bit samples (>=2).
REQ-003 SHALL have parameter WARMUP_SAMPLES, default 64, samples discarded after enable.
REQ-004 SHALL have parameter REP_CUTOFF, default 32, repetition-count health-test limit (>=2).
REQ-005 SHALL have port clk  input  1  single clock; one clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port raw_bit  input  1  asynchronous ring-oscillator (inverter-chain) output.
REQ-008 SHALL have port enable  input  1  level; 1 runs sampler, 0 returns to IDLE.
REQ-009 SHALL have port out_ready  input  1  consumer accepts word.
REQ-010 SHALL have port out_valid  output  1  out_data holds a complete word.
REQ-011 SHALL have port out_data  output  WORD_W  random word.
REQ-012 SHALL have port health_fail  output  1  sticky repetition-test failure.
REQ-013 SHALL have port busy  output  1  state != IDLE.

Function
REQ-014 SHALL pass raw_bit through a 2-flop synchronizer; only its output (s_bit) is used.
REQ-015 SHALL take one sample of s_bit each time a divider counter (0..SAMPLE_DIV-1) wraps; counter held at 0 in IDLE.
REQ-016 SHALL implement FSM IDLE, WARMUP, COLLECT, HOLD, FAIL.
REQ-017 IDLE->WARMUP when enable=1; any state->IDLE the cycle after enable=0 (partial word discarded, out_valid=0, health_fail cleared).
REQ-018 WARMUP SHALL discard exactly WARMUP_SAMPLES samples, then ->COLLECT.
REQ-019 COLLECT SHALL shift accepted bits into out_data LSB-first (first accepted bit ends in bit WORD_W-1 after WORD_W bits... no: bit 0 = first bit), and ->HOLD on the WORD_W-th bit.
REQ-020 HOLD SHALL assert out_valid with out_data stable; on out_valid&&out_ready ->COLLECT with bit count 0; bit collection stalls in HOLD.
REQ-021 Repetition test SHALL run on every sample in WARMUP, COLLECT and HOLD: count consecutive equal samples; count reaching REP_CUTOFF ->FAIL.
REQ-022 FAIL SHALL hold health_fail=1, out_valid=0, out_data=0 until enable=0 or reset; failure takes priority over a simultaneous handshake (word dropped).
REQ-023 out_valid SHALL never deassert without handshake except on enable=0, FAIL or reset.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force IDLE, out_valid=0, out_data=0, health_fail=0, busy=0, all counters and synchronizer flops 0, including mid-word.

Configuration
REQ-025 With TRNG_VN_DEBIAS_EN defined, accepted bits SHALL come from von Neumann pairs of consecutive COLLECT samples: 01->0, 10->1, 00/11 discarded; pair state cleared on HOLD exit and IDLE.
REQ-026 Without TRNG_VN_DEBIAS_EN, every COLLECT sample SHALL be an accepted bit.

Structure
REQ-027 Package trng_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-028 Synchronizer SHALL be sub-module trng_sync2 (2 flops, synchronous active-low reset).

Verification
REQ-029 Reset mid-COLLECT (rst_n=0 one cycle) -> next cycle all outputs 0, busy=0.
REQ-030 No debias, SAMPLE_DIV=4, WORD_W=32, raw_bit alternating per sample after warmup -> out_valid with out_data=32'hAAAA_AAAA or 32'h5555_5555, 64+32 samples after enable.
REQ-031 Debias, sample sequence 10,01,11,00 repeated -> accepted bits 1,0 per group; word 32'h5555_5555; 00/11 pairs dropped.
REQ-032 raw_bit stuck 1, REP_CUTOFF=32 -> health_fail=1 on 32nd sample, out_valid=0; enable 0 -> health_fail=0 next cycle.
REQ-033 out_ready=0 for 100 cycles in HOLD -> out_valid and out_data stable; out_ready=1 -> one transfer, then out_valid=0.
REQ-034 enable dropped in HOLD -> out_valid=0 and IDLE next cycle; re-enable repeats full warmup.
